// File: rtl/program_rom_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : program_rom_loadable
//  Description : Run-time loadable program memory. A valid/ready word stream
//                fills the array while the CPU is held; fetches beyond the
//                loaded length (or during a load) return NOP_WORD.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_rom_loadable #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_p,
    output logic [DATA_W-1:0] out_prom,
    input  logic              load_req,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   prog_len,
    output logic              ld_overflow
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int                c_depth   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_ptr_top = '1;
    localparam logic [ADDR_W-1:0] c_ptr_one = 1;
    localparam logic [ADDR_W:0]   c_len_one = 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_prog_len;
    logic              r_ld_overflow;
    logic [DATA_W-1:0] r_mem [c_depth];

    logic w_accept;
    logic w_at_top;
    logic w_start;

    assign w_accept    = ld_valid && (r_state == ST_LOAD);
    assign w_at_top    = (r_wr_ptr == c_ptr_top);
    assign w_start     = (r_state == ST_RUN) && load_req;
    assign prog_len    = r_prog_len;
    assign ld_overflow = r_ld_overflow;

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        ld_ready    = 1'b0;
        cpu_hold    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (load_req) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                cpu_hold = 1'b1;
                if (w_accept && (ld_last || w_at_top)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_hold    = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_wr_ptr      <= '0;
            r_prog_len    <= '0;
            r_ld_overflow <= 1'b0;
            r_addr        <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= addr_p;
            if (w_start) begin
                r_wr_ptr      <= '0;
                r_prog_len    <= '0;
                r_ld_overflow <= 1'b0;
            end
            if (w_accept) begin
                r_prog_len <= {1'b0, r_wr_ptr} + c_len_one;
                // Pointer parks at the top word rather than wrapping
                if (!w_at_top) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end else if (!ld_last) begin
                    r_ld_overflow <= 1'b1;
                end
            end
        end
    end

    // Array is never cleared; validity is tracked solely by prog_len
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= ld_data;
        end
    end

    always_comb begin
        out_prom = NOP_WORD;
        if ((r_state == ST_RUN) && ({1'b0, r_addr} < r_prog_len)) begin
            out_prom = r_mem[r_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_rom_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_rom_loadable
//  Description : Directed self-checking bench for program_rom_loadable
//                (ADDR_W=3 so the full-depth overflow path is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_rom_loadable;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] addr_p;
    logic [DATA_W-1:0] out_prom;
    logic              load_req;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              cpu_hold;
    logic [ADDR_W:0]   prog_len;
    logic              ld_overflow;

    int errors = 0;
    int checks = 0;

    program_rom_loadable #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_p      (addr_p),
        .out_prom    (out_prom),
        .load_req    (load_req),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .cpu_hold    (cpu_hold),
        .prog_len    (prog_len),
        .ld_overflow (ld_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        addr_p = a;
        tick();
        check(tag, 32'(out_prom), 32'(exp));
    endtask

    initial begin
        logic [DATA_W-1:0] prog [4];
        prog[0] = 16'h1004; prog[1] = 16'h1205; prog[2] = 16'h4200; prog[3] = 16'hB200;

        rst = 1'b1; addr_p = '0; load_req = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        tick(); tick();
        check("rst_prog_len", 32'(prog_len), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_overflow", 32'(ld_overflow), 32'd0);
        check("rst_out_prom", 32'(out_prom), 32'h0000);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) rd($sformatf("empty_rd%0d", i), ADDR_W'(i), 16'h0000);

        // Basic four-word load
        load_req = 1'b1; tick(); load_req = 1'b0;
        check("load_ready", 32'(ld_ready), 32'd1);
        check("load_hold", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("load_ready_w%0d", i), 32'(ld_ready), 32'd1);
            ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 3);
            tick();
            check($sformatf("load_len_w%0d", i), 32'(prog_len), 32'(i + 1));
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        check("done_hold", 32'(cpu_hold), 32'd1);
        check("done_ready", 32'(ld_ready), 32'd0);
        tick();
        check("run_hold", 32'(cpu_hold), 32'd0);
        check("run_len", 32'(prog_len), 32'd4);
        for (int i = 0; i < 4; i++) rd($sformatf("prog_rd%0d", i), ADDR_W'(i), prog[i]);
        rd("prog_rd4_nop", 3'd4, 16'h0000);

        // Backpressure: valid 1,0,0,1 with distinct data each cycle
        addr_p = 3'd0;
        load_req = 1'b1; tick(); load_req = 1'b0;
        ld_valid = 1'b1; ld_data = 16'hA001; tick();
        check("bp_len1", 32'(prog_len), 32'd1);
        check("bp_fetch_nop_in_load", 32'(out_prom), 32'h0000);
        ld_valid = 1'b0; ld_data = 16'hA002; tick();
        check("bp_len2", 32'(prog_len), 32'd1);
        ld_data = 16'hA003; tick();
        check("bp_len3", 32'(prog_len), 32'd1);
        ld_valid = 1'b1; ld_data = 16'hA004; ld_last = 1'b1; tick();
        check("bp_len4", 32'(prog_len), 32'd2);
        ld_valid = 1'b0; ld_last = 1'b0;
        tick();
        rd("bp_rd0", 3'd0, 16'hA001);
        rd("bp_rd1", 3'd1, 16'hA004);
        rd("bp_rd2_nop", 3'd2, 16'h0000);

        // load_req together with ld_valid in RUN, then load_req inside LOAD
        load_req = 1'b1; ld_valid = 1'b1; ld_data = 16'hDEAD; tick();
        check("sim_len0", 32'(prog_len), 32'd0);
        check("sim_ready", 32'(ld_ready), 32'd1);
        ld_data = 16'hC001; tick();
        check("reqload_len1", 32'(prog_len), 32'd1);
        load_req = 1'b0; ld_data = 16'hC002; ld_last = 1'b1; tick();
        check("reqload_len2", 32'(prog_len), 32'd2);
        ld_valid = 1'b0; ld_last = 1'b0;
        load_req = 1'b1; tick(); load_req = 1'b0;
        check("done_req_ignored_hold", 32'(cpu_hold), 32'd0);
        check("done_req_ignored_ready", 32'(ld_ready), 32'd0);
        rd("reqload_rd0", 3'd0, 16'hC001);
        rd("reqload_rd1", 3'd1, 16'hC002);

        // Full-depth load with ld_last on the top word: no overflow
        load_req = 1'b1; tick(); load_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1; ld_data = 16'h5000 + 16'(i); ld_last = (i == 7);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        check("lastdepth_ovf", 32'(ld_overflow), 32'd0);
        check("lastdepth_len", 32'(prog_len), 32'd8);
        tick();
        rd("lastdepth_rd7", 3'd7, 16'h5007);

        // Overflow: nine words, none marked last
        load_req = 1'b1; tick(); load_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1; ld_data = 16'hD000 + 16'(i);
            tick();
        end
        ld_data = 16'hD008;
        check("ovf_ready9", 32'(ld_ready), 32'd0);
        check("ovf_flag", 32'(ld_overflow), 32'd1);
        check("ovf_len", 32'(prog_len), 32'd8);
        tick();
        ld_valid = 1'b0;
        check("ovf_flag_run", 32'(ld_overflow), 32'd1);
        check("ovf_len_run", 32'(prog_len), 32'd8);
        rd("ovf_rd0", 3'd0, 16'hD000);
        rd("ovf_rd7", 3'd7, 16'hD007);
        load_req = 1'b1; tick(); load_req = 1'b0;
        check("ovf_cleared", 32'(ld_overflow), 32'd0);
        check("ovf_len_cleared", 32'(prog_len), 32'd0);

        // Reset in the middle of a load after two words
        ld_valid = 1'b1; ld_data = 16'hE000; tick();
        ld_data = 16'hE001; tick();
        check("mid_len2", 32'(prog_len), 32'd2);
        ld_valid = 1'b0;
        rst = 1'b1; #1;
        check("midrst_ready", 32'(ld_ready), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_len", 32'(prog_len), 32'd0);
        check("midrst_ovf", 32'(ld_overflow), 32'd0);
        tick();
        rst = 1'b0;
        rd("midrst_rd0", 3'd0, 16'h0000);
        rd("midrst_rd1", 3'd1, 16'h0000);
        check("midrst_ready_after", 32'(ld_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
